led_step_ctrl: RTL and testbench
================================

# led_step_ctrl

Upstream sequencing stage for the 8-LED running-light path: replaces the free-running 3-bit counter that drives the 3-8 decoder with a key-controlled stepper. It debounces three push-buttons (run/pause, direction, speed), generates its own step rate from the board clock, and outputs the 3-bit LED index plus a one-cycle step strobe. Its `idx` output connects directly to the decoder's `sw` input.

## Interface
- `CLK_HZ`, 12000000, board clock frequency in Hz
- `DEB_MS`, 20, debounce stable time in ms; `DEB_CYC = (CLK_HZ/1000)*DEB_MS`
- `WIDTH`, 32, prescaler/debounce counter width; must hold `CLK_HZ`
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  asynchronous reset, active-high
- `key_run`  in  1  raw button, active-low (pressed = 0); each press toggles run/pause
- `key_dir`  in  1  raw button, active-low; each press toggles direction
- `key_speed`  in  1  raw button, active-low; each press advances speed 0→1→2→3→0
- `idx`  out  3  current LED index, to the 3-8 decoder
- `step`  out  1  one-cycle pulse, high in the cycle `idx` takes a new value
- `running`  out  1  1 = stepping, 0 = paused
- `dir`  out  1  0 = up (idx+1), 1 = down (idx-1)
- `speed`  out  2  rate select; step period `P = CLK_HZ >> speed` cycles (1/2/4/8 Hz at default)

## Operation
- Reset values: `idx`=0, `step`=0, `running`=1, `dir`=0, `speed`=0; prescaler=0; all debouncers hold level 1 (released), counters 0.
- Per key: 2-flop synchronizer → debouncer. Debounce counter increments each cycle the synced level differs from the debounced level and clears when they match. When the counter is at `DEB_CYC-1` and still differs, the debounced level flips and the counter clears. Pulses shorter than `DEB_CYC` cycles are ignored.
- Press event: one-cycle internal pulse on a debounced 1→0 transition. Release (0→1) produces no event.
- Control FSM with two states, RUN and PAUSE. The run event moves RUN→PAUSE or PAUSE→RUN; `running` = (state == RUN).
- Dir event: `dir <= ~dir`. Speed event: `speed <= speed + 1`, wrapping 3→0.
- Prescaler counts only in RUN. At `P-1` it returns to 0, `idx` advances by one step in direction `dir`, and `step`=1 for that cycle.
- Wrap-around: going up, 7→0; going down, 0→7. Modulo-8 arithmetic, with no special case.
- Entering PAUSE clears the prescaler, holds `idx`, and forces `step`=0.
- A speed event clears the prescaler, so the new period starts from zero.
- A dir event does not clear the prescaler; the next step uses the new direction.
- Simultaneous events: all three keys are independent and may act in the same cycle. If a run→PAUSE event coincides with a prescaler terminal count, the pause wins: no step, and `idx` holds.

## Timing
- Key latency: raw key falls before sampling edge k. The debounced level flips at edge k+1+`DEB_CYC`. The control register (`running`/`dir`/`speed`) changes at edge k+2+`DEB_CYC`.
- After a resume (`running` rises at edge r), the first `step` comes at edge r+P. Subsequent steps come every P cycles.
- `step`, `idx`, `running`, `dir` and `speed` are all registered outputs; none is combinational from a key input.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronous). After release, the first step comes P cycles later.

## Test plan
Bench parameters: `CLK_HZ`=8000, `DEB_MS`=2, so `DEB_CYC`=16 and P = 8000/4000/2000/1000.
- Reset release with no keys pressed → `step` pulses every 8000 cycles; `idx` runs 0,1,…,7,0; `running`=1, `dir`=0, `speed`=0.
- `key_dir` held low for 40 cycles while `idx`=2 → `dir`=1 exactly 18 edges after first sampled low; then `idx` goes 1,0,7,6.
- `key_run` glitches low for 10 cycles, then a clean 30-cycle press → glitch gives no change. The clean press sets `running`=0, `idx` frozen, `step` stays 0. A second press resumes, and the first `step` comes 8000 cycles after `running` rises.
- `key_speed` pressed 3 times, then a 4th → step periods measured 4000, 2000, 1000, then back to 8000. The prescaler restarts at each change.
- Run event landing on the same cycle as terminal count → no `step`, `idx` unchanged, `running`=0.
- `rst` pulsed mid-period with `idx`=5, `dir`=1, `speed`=2, paused → all outputs return to reset values the same cycle; the next `step` comes 8000 cycles after release, with `idx` going 0→1.

Source files
------------

// File: rtl/led_step_ctrl.sv
// led_step_ctrl: key-controlled stepper that feeds the 3-8 LED decoder.
// Three active-low push-buttons go through a 2-flop synchronizer and a
// debouncer. Each press toggles run/pause, toggles the direction, or
// advances the speed. A prescaler derived from the board clock advances
// the 3-bit LED index.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-high
//   key_run    raw button, active-low: toggle run/pause
//   key_dir    raw button, active-low: toggle direction
//   key_speed  raw button, active-low: speed 0->1->2->3->0
//   idx        LED index, drives the decoder's sw input
//   step       one-cycle pulse in the cycle idx takes a new value
//   running    1 = stepping, 0 = paused
//   dir        0 = up, 1 = down
//   speed      rate select, step period = CLK_HZ >> speed cycles

// Synchronizer + debouncer + press detector for one active-low key.
module led_step_deb #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEB_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press_c
);

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(DEB_CYC - 1);

  logic [1:0]       sync;
  logic             level;
  logic             level_d;
  logic [WIDTH-1:0] cnt;

  // Released level is 1, so everything comes out of reset as "not pressed".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= 2'b11;
      level   <= 1'b1;
      level_d <= 1'b1;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], key};
      level_d <= level;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + WIDTH'(1);
      end
    end
  end

  // Only the debounced falling edge counts as a press.
  assign press_c = level_d & ~level;

endmodule

module led_step_ctrl #(
  parameter int unsigned CLK_HZ = 12000000,
  parameter int unsigned DEB_MS = 20,
  parameter int unsigned WIDTH  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_run,
  input  logic       key_dir,
  input  logic       key_speed,
  output logic [2:0] idx,
  output logic       step,
  output logic       running,
  output logic       dir,
  output logic [1:0] speed
);

  localparam int unsigned      DEB_CYC = (CLK_HZ / 1000) * DEB_MS;
  localparam logic [WIDTH-1:0] CLK_CYC = WIDTH'(CLK_HZ);

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] presc;
  logic [WIDTH-1:0] presc_nxt;
  logic [WIDTH-1:0] period_c;
  logic             terminal_c;
  logic [2:0]       idx_nxt;
  logic             step_nxt;
  logic             dir_nxt;
  logic [1:0]       speed_nxt;
  logic             run_ev_c;
  logic             dir_ev_c;
  logic             speed_ev_c;

  // One debouncer per key; the three keys act independently.
  led_step_deb #(.WIDTH(WIDTH), .DEB_CYC(DEB_CYC)) u_deb_run (
    .clk     (clk),
    .rst     (rst),
    .key     (key_run),
    .press_c (run_ev_c)
  );

  led_step_deb #(.WIDTH(WIDTH), .DEB_CYC(DEB_CYC)) u_deb_dir (
    .clk     (clk),
    .rst     (rst),
    .key     (key_dir),
    .press_c (dir_ev_c)
  );

  led_step_deb #(.WIDTH(WIDTH), .DEB_CYC(DEB_CYC)) u_deb_speed (
    .clk     (clk),
    .rst     (rst),
    .key     (key_speed),
    .press_c (speed_ev_c)
  );

  // Step period halves with each speed increment.
  assign period_c   = CLK_CYC >> speed;
  assign terminal_c = (presc == period_c - WIDTH'(1));

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      presc <= '0;
      idx   <= 3'd0;
      step  <= 1'b0;
      dir   <= 1'b0;
      speed <= 2'd0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      idx   <= idx_nxt;
      step  <= step_nxt;
      dir   <= dir_nxt;
      speed <= speed_nxt;
    end
  end

  // Next-state logic. A run or speed event restarts the period, so neither
  // can coincide with a step; a dir event leaves the prescaler running.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    idx_nxt   = idx;
    step_nxt  = 1'b0;
    dir_nxt   = dir;
    speed_nxt = speed;

    if (run_ev_c) begin
      state_nxt = (state == RUN) ? PAUSE : RUN;
    end
    if (dir_ev_c) begin
      dir_nxt = ~dir;
    end
    if (speed_ev_c) begin
      speed_nxt = speed + 2'd1;
    end

    if ((state_nxt == PAUSE) || run_ev_c || speed_ev_c) begin
      presc_nxt = '0;
    end else if (terminal_c) begin
      presc_nxt = '0;
      step_nxt  = 1'b1;
      idx_nxt   = dir ? (idx - 3'd1) : (idx + 3'd1);
    end else begin
      presc_nxt = presc + WIDTH'(1);
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_led_step_ctrl.sv
// Testbench for led_step_ctrl at CLK_HZ=8000, DEB_MS=2 (DEB_CYC=16).
module tb_led_step_ctrl;

  localparam int unsigned CLK_HZ  = 8000;
  localparam int unsigned DEB_MS  = 2;
  localparam int          DEB_CYC = 16;
  // First edge that samples a key low -> edge where the control register changes.
  localparam int          LAT     = DEB_CYC + 2;
  localparam int          KRUN    = 0;
  localparam int          KDIR    = 1;
  localparam int          KSPD    = 2;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [2:0] keys = 3'b111;
  logic [2:0] idx;
  logic       step;
  logic       running;
  logic       dir;
  logic [1:0] speed;

  led_step_ctrl #(.CLK_HZ(CLK_HZ), .DEB_MS(DEB_MS), .WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_run   (keys[KRUN]),
    .key_dir   (keys[KDIR]),
    .key_speed (keys[KSPD]),
    .idx       (idx),
    .step      (step),
    .running   (running),
    .dir       (dir),
    .speed     (speed)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_step = 0;
  int exp_idx   = 0;

  // Edges at which a key press is expected to take effect.
  int q_run[$];
  int q_dir[$];
  int q_spd[$];

  // Reference model: absolute edge number of the next due step.
  int m_idx   = 0;
  bit m_step  = 1'b0;
  bit m_run   = 1'b1;
  bit m_dir   = 1'b0;
  int m_speed = 0;
  int m_next  = 0;

  always @(posedge clk) begin
    bit er, ed, es, nr;
    int ns;
    cyc = cyc + 1;
    er = (q_run.size() > 0) && (q_run[0] == cyc);
    ed = (q_dir.size() > 0) && (q_dir[0] == cyc);
    es = (q_spd.size() > 0) && (q_spd[0] == cyc);
    if (er) void'(q_run.pop_front());
    if (ed) void'(q_dir.pop_front());
    if (es) void'(q_spd.pop_front());
    if (rst) begin
      m_idx = 0; m_step = 1'b0; m_run = 1'b1; m_dir = 1'b0; m_speed = 0;
      m_next = cyc + int'(CLK_HZ);
    end else begin
      nr = er ? !m_run : m_run;
      ns = es ? (m_speed + 1) % 4 : m_speed;
      m_step = 1'b0;
      if (nr && (er || es)) begin
        m_next = cyc + int'(CLK_HZ >> ns);
      end else if (nr && cyc == m_next) begin
        m_step = 1'b1;
        m_idx  = m_dir ? (m_idx + 7) % 8 : (m_idx + 1) % 8;
        m_next = cyc + int'(CLK_HZ >> m_speed);
      end
      m_run   = nr;
      m_speed = ns;
      if (ed) m_dir = !m_dir;
    end
  end

  // Pull a key low for len cycles; returns the edge where it should act, or -1.
  task automatic press(input int id, input int len, output int ev);
    ev = -1;
    keys[id] = 1'b0;
    if (len >= DEB_CYC) begin
      ev = cyc + 1 + LAT;
      case (id)
        KRUN:    q_run.push_back(ev);
        KDIR:    q_dir.push_back(ev);
        default: q_spd.push_back(ev);
      endcase
    end
    fork
      begin
        repeat (len) @(negedge clk);
        keys[id] = 1'b1;
      end
    join_none
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic test_reset();
    int rel, se;
    bit bad;
    checks++; if (idx !== 3'd0)    begin errors++; $display("FAIL reset_idx: got %0d want 0", idx); end
    checks++; if (step !== 1'b0)   begin errors++; $display("FAIL reset_step: got %b want 0", step); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL reset_running: got %b want 1", running); end
    checks++; if (dir !== 1'b0)    begin errors++; $display("FAIL reset_dir: got %b want 0", dir); end
    checks++; if (speed !== 2'd0)  begin errors++; $display("FAIL reset_speed: got %0d want 0", speed); end
    rel = cyc;
    rst = 1'b0;
    se = -1; bad = 1'b0;
    for (int i = 0; i < int'(CLK_HZ) + 100; i++) begin
      @(negedge clk);
      if (step === 1'b1) begin se = cyc; break; end
      if (idx !== 3'd0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL reset_hold: idx moved before first step, want 0"); end
    checks++; if (se != rel + int'(CLK_HZ)) begin errors++; $display("FAIL reset_first_step: edge %0d want %0d", se, rel + int'(CLK_HZ)); end
    checks++; if (idx !== 3'd1) begin errors++; $display("FAIL reset_first_idx: got %0d want 1", idx); end
    @(negedge clk);
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL step_pulse_width: got %b want 0", step); end
    last_step = se;
    exp_idx = 1;
  endtask

  task automatic test_speed();
    int ev, se, p;
    for (int s = 1; s <= 3; s++) begin
      p = int'(CLK_HZ >> s);
      @(negedge clk);
      press(KSPD, 24, ev);
      wait_edge(ev - 1);
      checks++; if (speed !== 2'(s - 1)) begin errors++; $display("FAIL speed_early%0d: got %0d want %0d", s, speed, s - 1); end
      wait_edge(ev);
      checks++; if (speed !== 2'(s)) begin errors++; $display("FAIL speed_set%0d: got %0d want %0d", s, speed, s); end
      se = -1;
      for (int i = 0; i < p + 50; i++) begin
        @(negedge clk);
        if (step === 1'b1) begin se = cyc; break; end
      end
      checks++; if (se - ev != p) begin errors++; $display("FAIL speed_period%0d: got %0d want %0d", s, se - ev, p); end
      exp_idx = (exp_idx + 1) % 8;
      checks++; if (idx !== 3'(exp_idx)) begin errors++; $display("FAIL speed_idx%0d: got %0d want %0d", s, idx, exp_idx); end
      last_step = se;
    end
  endtask

  task automatic test_dir();
    int ev, se;
    @(negedge clk);
    press(KDIR, 40, ev);
    wait_edge(ev - 1);
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL dir_early: got %b want 0", dir); end
    wait_edge(ev);
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL dir_flip: got %b want 1", dir); end
    for (int j = 0; j < 5; j++) begin
      se = -1;
      for (int i = 0; i < 1100; i++) begin
        @(negedge clk);
        if (step === 1'b1) begin se = cyc; break; end
      end
      exp_idx = (exp_idx + 7) % 8;
      checks++; if (se != last_step + 1000) begin errors++; $display("FAIL dir_period%0d: edge %0d want %0d", j, se, last_step + 1000); end
      checks++; if (idx !== 3'(exp_idx)) begin errors++; $display("FAIL dir_idx%0d: got %0d want %0d", j, idx, exp_idx); end
      last_step = se;
    end
  endtask

  task automatic test_speed_wrap();
    int ev, se;
    @(negedge clk);
    press(KSPD, 24, ev);
    wait_edge(ev);
    checks++; if (speed !== 2'd0) begin errors++; $display("FAIL speed_wrap: got %0d want 0", speed); end
    se = -1;
    for (int i = 0; i < int'(CLK_HZ) + 100; i++) begin
      @(negedge clk);
      if (step === 1'b1) begin se = cyc; break; end
    end
    exp_idx = (exp_idx + 7) % 8;
    checks++; if (se - ev != int'(CLK_HZ)) begin errors++; $display("FAIL speed_wrap_period: got %0d want %0d", se - ev, CLK_HZ); end
    checks++; if (idx !== 3'(exp_idx)) begin errors++; $display("FAIL speed_wrap_idx: got %0d want %0d", idx, exp_idx); end
    last_step = se;
  endtask

  task automatic test_pause_tc();
    int target, ev, ev2;
    bit bad;
    target = last_step + int'(CLK_HZ);
    wait_edge(target - 1 - LAT);
    press(KRUN, 30, ev);
    checks++; if (ev != target) begin errors++; $display("FAIL tc_align: event edge %0d want %0d", ev, target); end
    wait_edge(target - 1);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL tc_pre_running: got %b want 1", running); end
    wait_edge(target);
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL tc_step: got %b want 0", step); end
    checks++; if (idx !== 3'(exp_idx)) begin errors++; $display("FAIL tc_idx: got %0d want %0d", idx, exp_idx); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL tc_running: got %b want 0", running); end
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (step !== 1'b0 || idx !== 3'(exp_idx)) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL tc_hold: step or idx changed while paused, want idx %0d", exp_idx); end
    @(negedge clk);
    press(KRUN, 30, ev2);
    wait_edge(ev2);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL tc_resume: got %b want 1", running); end
    last_step = ev2;
  endtask

  task automatic test_run();
    int ev, se;
    bit bad;
    @(negedge clk);
    press(KRUN, 10, ev);
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (running !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL run_glitch: running changed on a 10-cycle glitch, want 1"); end
    @(negedge clk);
    press(KRUN, 30, ev);
    wait_edge(ev - 1);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_pause_early: got %b want 1", running); end
    wait_edge(ev);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL run_pause: got %b want 0", running); end
    bad = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (step !== 1'b0 || idx !== 3'(exp_idx)) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL run_frozen: step or idx changed while paused, want idx %0d", exp_idx); end
    @(negedge clk);
    press(KRUN, 30, ev);
    wait_edge(ev);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_resume: got %b want 1", running); end
    se = -1;
    for (int i = 0; i < int'(CLK_HZ) + 100; i++) begin
      @(negedge clk);
      if (step === 1'b1) begin se = cyc; break; end
    end
    exp_idx = (exp_idx + 7) % 8;
    checks++; if (se - ev != int'(CLK_HZ)) begin errors++; $display("FAIL run_resume_step: got %0d want %0d", se - ev, CLK_HZ); end
    checks++; if (idx !== 3'(exp_idx)) begin errors++; $display("FAIL run_resume_idx: got %0d want %0d", idx, exp_idx); end
    last_step = se;
  endtask

  task automatic test_reset_mid();
    int ev, rel, se;
    for (int s = 1; s <= 2; s++) begin
      @(negedge clk);
      press(KSPD, 24, ev);
      wait_edge(ev);
      checks++; if (speed !== 2'(s)) begin errors++; $display("FAIL rm_speed%0d: got %0d want %0d", s, speed, s); end
      wait_edge(ev + 30);
    end
    @(negedge clk);
    press(KRUN, 24, ev);
    wait_edge(ev);
    checks++; if ({idx, running, dir, speed} !== {3'(exp_idx), 1'b0, 1'b1, 2'd2})
      begin errors++; $display("FAIL rm_setup: idx/run/dir/speed %0d/%b/%b/%0d want %0d/0/1/2", idx, running, dir, speed, exp_idx); end
    wait_edge(ev + 300);
    #2 rst = 1'b1;
    #1;
    checks++; if ({idx, step, running, dir, speed} !== {3'd0, 1'b0, 1'b1, 1'b0, 2'd0})
      begin errors++; $display("FAIL rm_async: idx/step/run/dir/speed %0d/%b/%b/%b/%0d want 0/0/1/0/0", idx, step, running, dir, speed); end
    @(negedge clk);
    @(negedge clk);
    rel = cyc;
    rst = 1'b0;
    se = -1;
    for (int i = 0; i < int'(CLK_HZ) + 100; i++) begin
      @(negedge clk);
      if (step === 1'b1) begin se = cyc; break; end
    end
    checks++; if (se != rel + int'(CLK_HZ)) begin errors++; $display("FAIL rm_first_step: edge %0d want %0d", se, rel + int'(CLK_HZ)); end
    checks++; if (idx !== 3'd1) begin errors++; $display("FAIL rm_first_idx: got %0d want 1", idx); end
  endtask

  task automatic test_random();
    int ev, id, len, hold;
    bit [2:0] mask;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      id = int'($urandom_range(0, 2));
      mask = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'(1 << id);
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DEB_CYC - 1))
                                        : int'($urandom_range(DEB_CYC, 40));
      for (int k = 0; k < 3; k++) begin
        if (mask[k]) press(k, len, ev);
      end
      hold = len + int'($urandom_range(20, 60));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checks++;
        if ({idx, step, running, dir, speed} !== {3'(m_idx), m_step, m_run, m_dir, 2'(m_speed)}) begin
          errors++;
          $display("FAIL rnd edge %0d: idx/step/run/dir/speed %0d/%b/%b/%b/%0d want %0d/%b/%b/%b/%0d",
                   cyc, idx, step, running, dir, speed, m_idx, m_step, m_run, m_dir, m_speed);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_speed();
    test_dir();
    test_speed_wrap();
    test_pause_tc();
    test_run();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
